// File: rtl/digit_scanner_if.sv
// Scanner-side bundle: enable mask and hold in, anode strobes, digit index and
// slot/frame strobes out. The master side is the scanner; slave is the consumer.
interface digit_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = 2
);
  logic [NUM_DIGITS-1:0] enable;
  logic                  hold;
  logic [NUM_DIGITS-1:0] anode;
  logic [IDX_W-1:0]      digit_idx;
  logic                  tick;
  logic                  frame_done;

  modport master (
    input  enable,
    input  hold,
    output anode,
    output digit_idx,
    output tick,
    output frame_done
  );

  modport slave (
    output enable,
    output hold,
    input  anode,
    input  digit_idx,
    input  tick,
    input  frame_done
  );
endinterface

// File: rtl/digit_scanner.sv
// Multiplexed seven-segment digit scanner: active-low one-cold anode strobes with
// enable-mask skip, hold and tick/frame strobes. Define DIGIT_SCAN_BLANK_EN for slot-start blanking.
module digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int IDX_W        = 2,
  parameter int DIV_COUNT    = 250000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic            clk,
  input  logic            rst,
  digit_scanner_if.master bus
);
  localparam int               CNT_W    = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_COUNT - 1);

  generate
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("NUM_DIGITS must be in 2..8");
    end
    if ((1 << IDX_W) < NUM_DIGITS) begin : g_bad_idx
      $error("IDX_W too narrow for NUM_DIGITS");
    end
    if (DIV_COUNT < 2 || BLANK_CYCLES >= DIV_COUNT) begin : g_bad_div
      $error("DIV_COUNT must be >= 2 and exceed BLANK_CYCLES");
    end
  endgenerate

  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      idx, idx_next, idx_search;
  logic [NUM_DIGITS-1:0] anode, anode_next;
  logic                  tick, tick_next;
  logic                  frame_done, frame_done_next;
  logic                  any_en, slot_end;

  // Next enabled digit strictly above cur, wrapping to the lowest enabled one;
  // a lone enabled digit therefore finds itself.
  function automatic logic [IDX_W-1:0] next_digit(input logic [IDX_W-1:0]      cur,
                                                  input logic [NUM_DIGITS-1:0] en);
    logic [IDX_W-1:0] res;
    logic             found;
    res   = cur;
    found = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (!found && en[j] && (j > int'(cur))) begin
        res   = IDX_W'(j);
        found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (!found && en[j]) begin
        res   = IDX_W'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    any_en          = |bus.enable;
    slot_end        = (cnt == CNT_LAST) && !bus.hold;
    idx_search      = next_digit(idx, bus.enable);
    cnt_next        = cnt;
    idx_next        = idx;
    tick_next       = 1'b0;
    frame_done_next = 1'b0;

    if (!bus.hold) begin
      cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
    if (slot_end && any_en) begin
      idx_next        = idx_search;
      tick_next       = 1'b1;
      frame_done_next = (idx_search <= idx);
    end

    anode_next = ~((NUM_DIGITS'(1) << idx_next) & bus.enable);
`ifdef DIGIT_SCAN_BLANK_EN
    // Keep the digit dark while segment data settles after a change.
    if (cnt_next < CNT_W'(BLANK_CYCLES)) begin
      anode_next = '1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      anode      <= '1;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      idx        <= idx_next;
      anode      <= anode_next;
      tick       <= tick_next;
      frame_done <= frame_done_next;
    end
  end

  assign bus.anode      = anode;
  assign bus.digit_idx  = idx;
  assign bus.tick       = tick;
  assign bus.frame_done = frame_done;
endmodule
